// File: rtl/regfile_mp_scoreboard_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_mp_scoreboard_if
// Brief    : Read/write/issue bundle between ID/WB stages and the register file.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface regfile_mp_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_WR-1:0]        RegWrite;
  logic [NUM_WR*ADDR_W-1:0] Write_reg;
  logic [NUM_WR*DATA_W-1:0] Write_data;
  logic [NUM_RD*ADDR_W-1:0] Read_reg;
  logic [NUM_RD*DATA_W-1:0] Read_data;
  logic [NUM_RD-1:0]        Read_busy;
  logic                     Issue_valid;
  logic [ADDR_W-1:0]        Issue_reg;
  logic                     Flush;
  logic [(2**ADDR_W)-1:0]   Pending;

  modport master (
    output RegWrite, Write_reg, Write_data, Read_reg, Issue_valid, Issue_reg, Flush,
    input  Read_data, Read_busy, Pending
  );

  modport slave (
    input  RegWrite, Write_reg, Write_data, Read_reg, Issue_valid, Issue_reg, Flush,
    output Read_data, Read_busy, Pending
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_mp_scoreboard
// Brief    : Multi-port register file with write bypass, hardwired r0 and a
//            per-register pending scoreboard for hazard detection.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module regfile_mp_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_mp_scoreboard_if.slave bus
);
  localparam int c_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        r_regs [c_DEPTH];
  logic [c_DEPTH-1:0]       r_pending;
  logic [c_DEPTH-1:0]       w_wr_hit;
  logic [DATA_W-1:0]        w_wr_data [c_DEPTH];
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-numbered effective port wins.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < c_DEPTH; i++) begin
      w_wr_data[i] = '0;
    end
    for (int p = 0; p < NUM_WR; p++) begin
      if (bus.RegWrite[p] && (bus.Write_reg[p*ADDR_W +: ADDR_W] != '0)) begin
        w_wr_hit[bus.Write_reg[p*ADDR_W +: ADDR_W]]  = 1'b1;
        w_wr_data[bus.Write_reg[p*ADDR_W +: ADDR_W]] = bus.Write_data[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (bus.Read_reg[r*ADDR_W +: ADDR_W] != '0) begin
        if (w_wr_hit[bus.Read_reg[r*ADDR_W +: ADDR_W]]) begin
          w_rd_data[r*DATA_W +: DATA_W] = w_wr_data[bus.Read_reg[r*ADDR_W +: ADDR_W]];
        end else begin
          w_rd_data[r*DATA_W +: DATA_W] = r_regs[bus.Read_reg[r*ADDR_W +: ADDR_W]];
          w_rd_busy[r] = r_pending[bus.Read_reg[r*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  assign bus.Read_data = w_rd_data;
  assign bus.Read_busy = w_rd_busy;
  assign bus.Pending   = r_pending;

  // Bit 0 of the scoreboard and r0 are only ever written by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 1; i < c_DEPTH; i++) begin
        if (w_wr_hit[i]) begin
          r_regs[i] <= w_wr_data[i];
        end
        if (bus.Flush) begin
          r_pending[i] <= 1'b0;
        end else if (bus.Issue_valid && (bus.Issue_reg == ADDR_W'(i))) begin
          r_pending[i] <= 1'b1;
        end else if (w_wr_hit[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end
endmodule
`default_nettype wire
